// File: rtl/line_window_buffer_pkg.sv
// Shared constants and helpers for the line window buffer and its line memories.
package line_window_buffer_pkg;

   localparam int DATA_W_DEF    = 8;
   localparam int ADDR_BITS_DEF = 11;
   localparam int MAX_TAPS      = 8;
   localparam int ROWS_W        = 4;

   // Bit offset of tap slice k inside the packed output column.
   function automatic int tap_lsb(input int tap, input int width);
      return tap * width;
   endfunction

endpackage

// File: rtl/line_window_buffer_line_ram_rf.sv
// Simple dual-port, single-clock, read-first line memory with an enable-gated registered read.
module line_ram_rf
   import line_window_buffer_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_BITS = ADDR_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 i_rst,
   input  logic                 i_we,
   input  logic [ADDR_BITS-1:0] i_waddr,
   input  logic [DATA_W-1:0]    i_wdata,
   input  logic                 i_re,
   input  logic [ADDR_BITS-1:0] i_raddr,
   output logic [DATA_W-1:0]    o_rdata
);

   (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [0:(2**ADDR_BITS)-1];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Output register reset maps onto the BRAM output-register reset; contents are never cleared.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/line_window_buffer.sv
// Multi-line buffer: emits, per accepted pixel, the column of NUM_TAPS pixels at the same column index.
module line_window_buffer
   import line_window_buffer_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_BITS = ADDR_BITS_DEF,
   parameter int NUM_TAPS  = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   input  logic [DATA_W-1:0]            s_data,
   input  logic                         s_sof,
   input  logic                         s_eol,
   output logic                         m_valid,
   output logic [NUM_TAPS*DATA_W-1:0]   m_data,
   output logic [ADDR_BITS-1:0]         m_col,
   output logic                         m_eol,
   output logic                         m_sof,
   output logic [ROWS_W-1:0]            m_rows,
   output logic                         m_ovf,
   output logic                         m_len_err
);

   logic [ADDR_BITS-1:0] r_col, r_len, r_out_col, r_wr_addr;
   logic                 r_valid, r_sof, r_eol, r_ovf, r_len_err, r_wrapped;
   logic                 r_wr_en, r_byp;
   logic [ROWS_W-1:0]    r_rows;
   logic [DATA_W-1:0]    r_tap0;
   logic [DATA_W-1:0]    r_byp_data [0:NUM_TAPS-2];
   logic [DATA_W-1:0]    w_ram_q    [0:NUM_TAPS-2];
   logic [DATA_W-1:0]    w_tap      [0:NUM_TAPS-1];

   logic [ADDR_BITS-1:0] w_addr;
   logic                 w_at_max, w_ovf_evt, w_len_evt;
   logic [ROWS_W-1:0]    w_rows_base, w_rows_next;

   always_comb begin
      w_addr      = s_sof ? '0 : r_col;
      w_at_max    = (w_addr == {ADDR_BITS{1'b1}});
      w_ovf_evt   = w_at_max && !s_eol;
      w_rows_base = (s_sof || r_wrapped) ? '0 : r_rows;
      w_rows_next = w_rows_base;
      if (s_eol && (w_rows_base < ROWS_W'(NUM_TAPS - 1))) begin
         w_rows_next = w_rows_base + 1'b1;
      end
      w_len_evt   = s_eol && (w_rows_base != '0) && (w_addr != r_len);
   end

   // Memory writes land one cycle after the beat; a same-address beat right behind sees the pending data.
   always_comb begin
      w_tap[0] = r_tap0;
      for (int k = 1; k < NUM_TAPS; k++) begin
         w_tap[k] = r_byp ? r_byp_data[k-1] : w_ram_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col     <= '0;
         r_len     <= '0;
         r_out_col <= '0;
         r_wr_addr <= '0;
         r_valid   <= 1'b0;
         r_sof     <= 1'b0;
         r_eol     <= 1'b0;
         r_ovf     <= 1'b0;
         r_len_err <= 1'b0;
         r_wrapped <= 1'b0;
         r_wr_en   <= 1'b0;
         r_byp     <= 1'b0;
         r_rows    <= '0;
         r_tap0    <= '0;
         for (int k = 0; k < NUM_TAPS - 1; k++) begin
            r_byp_data[k] <= '0;
         end
      end else begin
         r_valid <= s_valid;
         r_sof   <= s_valid && s_sof;
         r_eol   <= s_valid && s_eol;
         r_wr_en <= s_valid;
         if (s_valid) begin
            r_col     <= (s_eol || w_at_max) ? '0 : w_addr + 1'b1;
            r_out_col <= w_addr;
            r_wr_addr <= w_addr;
            r_tap0    <= s_data;
            r_byp     <= r_wr_en && (r_wr_addr == w_addr);
            for (int k = 0; k < NUM_TAPS - 1; k++) begin
               r_byp_data[k] <= w_tap[k];
            end
            r_rows    <= w_rows_next;
            r_wrapped <= w_ovf_evt;
            r_ovf     <= (r_ovf && !s_sof) || w_ovf_evt;
            r_len_err <= (r_len_err && !s_sof) || w_len_evt;
            if (s_eol) begin
               r_len <= w_addr;
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_TAPS - 1; gi++) begin : g_line
         line_ram_rf #(
            .DATA_W    (DATA_W),
            .ADDR_BITS (ADDR_BITS)
         ) u_ram (
            .clk     (clk),
            .i_rst   (rst),
            .i_we    (r_wr_en),
            .i_waddr (r_wr_addr),
            .i_wdata (w_tap[gi]),
            .i_re    (s_valid),
            .i_raddr (w_addr),
            .o_rdata (w_ram_q[gi])
         );
      end
      for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_pack
         assign m_data[tap_lsb(gi, DATA_W) +: DATA_W] = w_tap[gi];
      end
   endgenerate

   assign m_valid   = r_valid;
   assign m_col     = r_out_col;
   assign m_sof     = r_sof;
   assign m_eol     = r_eol;
   assign m_rows    = r_rows;
   assign m_ovf     = r_ovf;
   assign m_len_err = r_len_err;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed and randomized stimulus for line_window_buffer, checked against a line-history model.
module tb_line_window_buffer;

   localparam int DW    = 8;
   localparam int AB    = 3;
   localparam int NT    = 3;
   localparam int DEPTH = 2**AB;

   logic             clk = 1'b0;
   logic             rst, s_valid, s_sof, s_eol;
   logic [DW-1:0]    s_data;
   logic             m_valid, m_eol, m_sof, m_ovf, m_len_err;
   logic [NT*DW-1:0] m_data;
   logic [AB-1:0]    m_col;
   logic [3:0]       m_rows;

   int checks = 0;
   int errors = 0;

   // Model: hist[k][c] is the pixel at column c written k lines ago; ok marks it as written since reset.
   int hist [1:NT-1][0:DEPTH-1];
   bit ok   [1:NT-1][0:DEPTH-1];
   int mcol, mrows, mlen;
   bit movf, merr, mwrap;

   int  etap [0:NT-1];
   bit  eok  [0:NT-1];
   bit  e_valid, e_sof, e_eol;
   int  e_col;

   always #5 clk = ~clk;

   line_window_buffer #(
      .DATA_W    (DW),
      .ADDR_BITS (AB),
      .NUM_TAPS  (NT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_sof     (s_sof),
      .s_eol     (s_eol),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_col     (m_col),
      .m_eol     (m_eol),
      .m_sof     (m_sof),
      .m_rows    (m_rows),
      .m_ovf     (m_ovf),
      .m_len_err (m_len_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit v, input logic [DW-1:0] d, input bit sof, input bit eol, input bit r);
      int c, rb;
      bit ovf_evt;
      rst = r; s_valid = v; s_data = d; s_sof = sof; s_eol = eol;
      if (r) begin
         mcol = 0; mrows = 0; mlen = 0; movf = 0; merr = 0; mwrap = 0;
         for (int k = 1; k < NT; k++)
            for (int i = 0; i < DEPTH; i++) ok[k][i] = 0;
         e_valid = 0; e_sof = 0; e_eol = 0; e_col = 0;
      end else if (v) begin
         c  = sof ? 0 : mcol;
         rb = (sof || mwrap) ? 0 : mrows;
         etap[0] = int'(d); eok[0] = 1;
         for (int k = 1; k < NT; k++) begin
            etap[k] = hist[k][c]; eok[k] = ok[k][c];
         end
         for (int k = NT - 1; k > 1; k--) begin
            hist[k][c] = hist[k-1][c]; ok[k][c] = ok[k-1][c];
         end
         hist[1][c] = int'(d); ok[1][c] = 1;
         if (sof) begin movf = 0; merr = 0; end
         if (eol) begin
            if (rb > 0 && c != mlen) merr = 1;
            mlen = c;
         end
         ovf_evt = (c == DEPTH - 1) && !eol;
         if (ovf_evt) movf = 1;
         mrows = (eol && rb < NT - 1) ? rb + 1 : rb;
         mwrap = ovf_evt;
         mcol  = (eol || c == DEPTH - 1) ? 0 : c + 1;
         e_valid = 1; e_sof = sof; e_eol = eol; e_col = c;
      end else begin
         e_valid = 0; e_sof = 0; e_eol = 0;
      end
      @(posedge clk);
      #1;
      $display("step v=%0b d=%02h sof=%0b eol=%0b rst=%0b -> valid=%0b col=%0d rows=%0d data=%06h ovf=%0b lerr=%0b",
               v, d, sof, eol, r, m_valid, m_col, m_rows, m_data, m_ovf, m_len_err);
      chk("m_valid", 32'(m_valid), 32'(e_valid));
      chk("m_sof", 32'(m_sof), 32'(e_sof));
      chk("m_eol", 32'(m_eol), 32'(e_eol));
      chk("m_rows", 32'(m_rows), 32'(mrows));
      chk("m_ovf", 32'(m_ovf), 32'(movf));
      chk("m_len_err", 32'(m_len_err), 32'(merr));
      if (r) begin
         chk("rst_m_data", 32'(m_data), 32'd0);
         chk("rst_m_col", 32'(m_col), 32'd0);
      end else if (v) begin
         chk("m_col", 32'(m_col), 32'(e_col));
         for (int k = 0; k < NT; k++) begin
            if (eok[k]) chk($sformatf("tap%0d", k), 32'(m_data[k*DW +: DW]), 32'(etap[k]));
         end
      end
   endtask

   initial begin
      int L, pos;
      bit sofb, eolb;
      for (int k = 1; k < NT; k++)
         for (int i = 0; i < DEPTH; i++) begin hist[k][i] = 0; ok[k][i] = 0; end
      rst = 1; s_valid = 0; s_data = '0; s_sof = 0; s_eol = 0;

      step(0, 8'h00, 0, 0, 1);
      step(0, 8'h00, 0, 0, 1);
      step(0, 8'h00, 0, 0, 0);

      // Three contiguous 4-pixel lines
      for (int row = 0; row < 3; row++)
         for (int col = 0; col < 4; col++) begin
            step(1, 8'(8'h10 + row*4 + col), row == 0 && col == 0, col == 3, 0);
            if (row == 2 && col == 1) chk("l2c1_window", 32'(m_data), 32'h111519);
            if (col == 3) chk("rows_after_line", 32'(m_rows), 32'(row + 1 > 2 ? 2 : row + 1));
         end

      // Same frame with a gap after every beat
      for (int row = 0; row < 3; row++)
         for (int col = 0; col < 4; col++) begin
            step(1, 8'(8'h10 + row*4 + col), row == 0 && col == 0, col == 3, 0);
            if (row == 2 && col == 1) chk("gap_l2c1_window", 32'(m_data), 32'h111519);
            step(0, 8'h00, 0, 0, 0);
         end

      // Line overrun wraps col and sets the sticky overflow
      for (int i = 0; i < 9; i++) step(1, 8'(8'h40 + i), i == 0, 0, 0);
      chk("ovf_wrap_col", 32'(m_col), 32'd0);
      chk("ovf_set", 32'(m_ovf), 32'd1);
      step(1, 8'h50, 1, 0, 0);
      chk("ovf_cleared_by_sof", 32'(m_ovf), 32'd0);
      chk("rows_cleared_by_sof", 32'(m_rows), 32'd0);
      step(1, 8'h51, 0, 1, 0);

      // 4-pixel line followed by a 5-pixel line
      for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), i == 0, i == 3, 0);
      for (int i = 0; i < 5; i++) step(1, 8'(8'h70 + i), 0, i == 4, 0);
      chk("len_err_set", 32'(m_len_err), 32'd1);
      for (int i = 0; i < 3; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
      chk("len_err_sticky", 32'(m_len_err), 32'd1);
      step(1, 8'h90, 1, 0, 0);
      chk("len_err_cleared", 32'(m_len_err), 32'd0);

      // Reset in the middle of a line
      step(1, 8'hA0, 0, 0, 0);
      step(1, 8'hA1, 0, 0, 0);
      chk("pre_rst_col", 32'(m_col), 32'd2);
      step(0, 8'h00, 0, 0, 1);
      chk("rst_quiet", 32'(m_valid), 32'd0);
      step(1, 8'hB0, 0, 0, 0);
      chk("post_rst_col0", 32'(m_col), 32'd0);
      step(1, 8'hB1, 0, 1, 0);

      // Single-pixel line
      step(1, 8'hAA, 1, 1, 0);
      chk("sp_col", 32'(m_col), 32'd0);
      chk("sp_slice0", 32'(m_data[DW-1:0]), 32'hAA);
      chk("sp_rows", 32'(m_rows), 32'd1);

      // Randomized lines of varying length, gaps, frame starts and occasional reset
      L = 4;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            step(0, 8'h00, 0, 0, 1);
         end else if ($urandom_range(0, 3) == 0) begin
            step(0, 8'($urandom), 0, 0, 0);
         end else begin
            sofb = ($urandom_range(0, 29) == 0);
            pos  = sofb ? 0 : mcol;
            eolb = (pos == L - 1) || ($urandom_range(0, 49) == 0);
            if (eolb && $urandom_range(0, 7) == 0) L = $urandom_range(1, 9);
            step(1, 8'($urandom), sofb, eolb, 0);
         end
      end

      s_valid = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
